// File: rtl/hex_display_decoder.sv
// hex_display_decoder
//   Read-back monitor for the six seven-segment display buses. Samples the
//   HEX5..HEX0 segment lines and waits for them to hold steady. It then decodes
//   each active-low glyph back to a hex nibble and offers the snapshot to a
//   consumer over a valid/ack handshake.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   HEX5..HEX0      segment buses, active-low, bit order {dp,g,f,e,d,c,b,a}
//   digits          decoded nibbles, HEX5 in [23:20] ... HEX0 in [3:0]
//   sum_out         copy of digits[3:0]
//   digit_ok        per digit: recognised hex glyph
//   blank           per digit: all seven segments dark
//   dp              per digit: decimal point lit
//   decode_err      some captured digit is neither a glyph nor blank
//   out_valid       snapshot pending for the consumer
//   out_ack         consumer accepts the pending snapshot
//   overrun         sticky: a pending snapshot was overwritten before ack
module hex_display_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  HEX5,
    input  logic [7:0]  HEX4,
    input  logic [7:0]  HEX3,
    input  logic [7:0]  HEX2,
    input  logic [7:0]  HEX1,
    input  logic [7:0]  HEX0,
    output logic [23:0] digits,
    output logic [3:0]  sum_out,
    output logic [5:0]  digit_ok,
    output logic [5:0]  blank,
    output logic [5:0]  dp,
    output logic        decode_err,
    output logic        out_valid,
    input  logic        out_ack,
    output logic        overrun
);

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned BUS_W      = NUM_DIGITS * SEG_W;
    localparam int unsigned DIG_W      = NUM_DIGITS * NIB_W;
    localparam int unsigned CNT_W      = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_SETTLING = 1'b0,
        ST_STABLE   = 1'b1
    } state_t;

    // Maps the seven segment bits back to {recognised, nibble}; unknown
    // patterns (including blank) return {0, 0}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h00;
        case (seg)
            7'h40: res = 5'h10;
            7'h79: res = 5'h11;
            7'h24: res = 5'h12;
            7'h30: res = 5'h13;
            7'h19: res = 5'h14;
            7'h12: res = 5'h15;
            7'h02: res = 5'h16;
            7'h78: res = 5'h17;
            7'h00: res = 5'h18;
            7'h10: res = 5'h19;
            7'h08: res = 5'h1A;
            7'h03: res = 5'h1B;
            7'h46: res = 5'h1C;
            7'h21: res = 5'h1D;
            7'h06: res = 5'h1E;
            7'h0E: res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [BUS_W-1:0] w_in;
    logic             w_same;

    logic [BUS_W-1:0] r_s;
    logic [BUS_W-1:0] r_snap;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    state_t           r_state;

    state_t           w_state_next;
    logic             w_capture;

    logic [DIG_W-1:0]      w_digits;
    logic [NUM_DIGITS-1:0] w_ok;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] w_dp;
    logic                  w_err;

    logic w_valid_next;
    logic w_overrun_next;

    assign w_in   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    // Compares the value about to be sampled with the current sample.
    assign w_same = (w_in == r_s);

    // Input sample register and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s   <= '0;
            r_cnt <= '0;
        end else begin
            r_s <= w_in;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SETTLING;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and capture decision. While settling, the count only
    // advances one step per unchanged cycle, so it can never skip CNT_LAST.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_SETTLING: begin
                if (w_same && (r_cnt == CNT_LAST)) begin
                    w_state_next = ST_STABLE;
                    if ((r_s != r_snap) || r_first) begin
                        w_capture = 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                if (!w_same) begin
                    w_state_next = ST_SETTLING;
                end
            end
            default: begin
                w_state_next = ST_SETTLING;
            end
        endcase
    end

    // Decode the settled sample into per-digit fields.
    always_comb begin
        logic [4:0]       glyph;
        logic [SEG_W-1:0] seg;
        w_digits = '0;
        w_ok     = '0;
        w_blank  = '0;
        w_dp     = '0;
        glyph    = '0;
        seg      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg   = r_s[i*SEG_W +: SEG_W];
            glyph = decode_glyph(seg[6:0]);
            w_digits[i*NIB_W +: NIB_W] = glyph[3:0];
            w_ok[i]    = glyph[4];
            w_blank[i] = (seg[6:0] == 7'h7F);
            w_dp[i]    = ~seg[7];
        end
        w_err = |(~w_ok & ~w_blank);
    end

    // Handshake: a capture always leaves a snapshot pending; an ack only
    // retires it when no new capture lands on the same edge.
    always_comb begin
        w_valid_next   = out_valid;
        w_overrun_next = overrun;
        if (w_capture) begin
            w_valid_next = 1'b1;
            if (out_valid && !out_ack) begin
                w_overrun_next = 1'b1;
            end
        end else if (out_ack) begin
            w_valid_next = 1'b0;
        end
    end

    // Snapshot, first-capture flag and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap     <= '0;
            r_first    <= 1'b1;
            digits     <= '0;
            sum_out    <= '0;
            digit_ok   <= '0;
            blank      <= '0;
            dp         <= '0;
            decode_err <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= w_valid_next;
            overrun   <= w_overrun_next;
            if (w_capture) begin
                r_snap     <= r_s;
                r_first    <= 1'b0;
                digits     <= w_digits;
                sum_out    <= w_digits[NIB_W-1:0];
                digit_ok   <= w_ok;
                blank      <= w_blank;
                dp         <= w_dp;
                decode_err <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_decoder.sv
// Scoreboard bench for hex_display_decoder (STABLE_CYCLES = 4).
module tb_hex_display_decoder;

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  ok;
        logic [5:0]  blank;
        logic [5:0]  dp;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] hex_bus;
    logic [23:0] digits;
    logic [3:0]  sum_out;
    logic [5:0]  digit_ok;
    logic [5:0]  blank;
    logic [5:0]  dp;
    logic        decode_err;
    logic        out_valid;
    logic        out_ack;
    logic        overrun;

    logic mon_ack  = 1'b0;
    logic stim_ack = 1'b0;
    bit   mon_en   = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int n_seen  = 0;

    exp_t sb_q[$];
    exp_t m_exp;

    assign out_ack = mon_ack | stim_ack;

    always #5 clk = ~clk;

    hex_display_decoder #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .HEX5       (hex_bus[47:40]),
        .HEX4       (hex_bus[39:32]),
        .HEX3       (hex_bus[31:24]),
        .HEX2       (hex_bus[23:16]),
        .HEX1       (hex_bus[15:8]),
        .HEX0       (hex_bus[7:0]),
        .digits     (digits),
        .sum_out    (sum_out),
        .digit_ok   (digit_ok),
        .blank      (blank),
        .dp         (dp),
        .decode_err (decode_err),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic push_exp(input logic [23:0] d, input logic [5:0] ok,
                            input logic [5:0] bl, input logic [5:0] p, input logic e);
        exp_t x;
        x.digits = d; x.ok = ok; x.blank = bl; x.dp = p; x.err = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_seen(input int target);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (n_seen >= target) break;
        end
        chk("capture_count", 32'(n_seen), 32'(target));
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Monitor: compares every presented snapshot against the scoreboard and acks it.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_ack) begin
                mon_ack = 1'b0;
            end else if (mon_en && out_valid && !rst) begin
                n_seen++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_capture", 32'(digits), 32'hFFFF_FFFF);
                end else begin
                    m_exp = sb_q.pop_front();
                    chk("digits",     32'(digits),     32'(m_exp.digits));
                    chk("sum_out",    32'(sum_out),    32'(m_exp.digits[3:0]));
                    chk("digit_ok",   32'(digit_ok),   32'(m_exp.ok));
                    chk("blank",      32'(blank),      32'(m_exp.blank));
                    chk("dp",         32'(dp),         32'(m_exp.dp));
                    chk("decode_err", 32'(decode_err), 32'(m_exp.err));
                end
                mon_ack = 1'b1;
            end
        end
    end

    initial begin
        int k;
        rst     = 1'b1;
        hex_bus = {6{8'hFF}};
        repeat (2) @(negedge clk);
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_digits",  32'(digits),    32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_blank",   32'(blank),     32'd0);

        // All blank from reset release: one capture, none afterwards.
        push_exp(24'h000000, 6'h00, 6'h3F, 6'h00, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_seen(1);
        repeat (10) @(negedge clk);
        chk("blank_single_capture", 32'(n_seen), 32'd1);

        // 123456: capture exactly four edges after the first sample.
        push_exp(24'h123456, 6'h3F, 6'h00, 6'h00, 1'b0);
        hex_bus = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
        for (k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("latency_edges", 32'(k), 32'd4);
        wait_seen(2);
        repeat (6) @(negedge clk);

        // HEX0 toggling 9/8 never settles; final 8 is captured once.
        push_exp(24'h123458, 6'h3F, 6'h00, 6'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            hex_bus[7:0] = (i % 2 == 0) ? 8'h90 : 8'h80;
            repeat (2) @(negedge clk);
        end
        chk("toggle_no_capture", 32'(n_seen), 32'd2);
        wait_seen(3);
        repeat (10) @(negedge clk);
        chk("toggle_single_capture", 32'(n_seen), 32'd3);

        // Two captures without ack: overrun, second pattern retained.
        mon_en  = 1'b0;
        hex_bus = {6{8'hC0}};
        wait_valid();
        @(negedge clk);
        hex_bus = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
        repeat (8) @(negedge clk);
        chk("overrun_set",      32'(overrun),   32'd1);
        chk("overrun_valid",    32'(out_valid), 32'd1);
        push_exp(24'hFEDCBA, 6'h3F, 6'h00, 6'h00, 1'b0);
        mon_en = 1'b1;
        wait_seen(4);
        repeat (5) @(negedge clk);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset, then ack coinciding with the second capture: no overrun.
        mon_en  = 1'b0;
        rst     = 1'b1;
        hex_bus = {6{8'hC0}};
        @(negedge clk);
        chk("overrun_cleared", 32'(overrun), 32'd0);
        rst = 1'b0;
        push_exp(24'h000000, 6'h3F, 6'h00, 6'h00, 1'b0);
        mon_en = 1'b1;
        wait_seen(5);
        repeat (4) @(negedge clk);
        mon_en  = 1'b0;
        hex_bus = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
        wait_valid();
        @(negedge clk);
        hex_bus = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
        repeat (4) @(posedge clk);
        @(negedge clk);
        stim_ack = 1'b1;
        @(posedge clk); #1;
        stim_ack = 1'b0;
        chk("ack_capture_valid",   32'(out_valid), 32'd1);
        chk("ack_capture_overrun", 32'(overrun),   32'd0);
        chk("ack_capture_digits",  32'(digits),    32'h00FEDCBA);
        push_exp(24'hFEDCBA, 6'h3F, 6'h00, 6'h00, 1'b0);
        mon_en = 1'b1;
        wait_seen(6);
        chk("ack_capture_no_overrun", 32'(overrun), 32'd0);

        // Unknown glyph on HEX2, decimal point lit on HEX3.
        push_exp(24'h003000, 6'h3B, 6'h00, 6'h08, 1'b1);
        hex_bus = {8'hC0, 8'hC0, 8'h30, 8'hFE, 8'hC0, 8'hC0};
        wait_seen(7);
        repeat (4) @(negedge clk);

        // Reset while a snapshot is pending, then recapture the same pattern.
        mon_en  = 1'b0;
        hex_bus = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
        wait_valid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_valid",   32'(out_valid),  32'd0);
        chk("async_rst_digits",  32'(digits),     32'd0);
        chk("async_rst_sum",     32'(sum_out),    32'd0);
        chk("async_rst_ok",      32'(digit_ok),   32'd0);
        chk("async_rst_err",     32'(decode_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(24'h012345, 6'h3F, 6'h00, 6'h00, 1'b0);
        mon_en = 1'b1;
        wait_seen(8);
        repeat (6) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hex_display_decoder.md
# hex_display_decoder

Read-back monitor for the six DE10-Lite seven-segment display buses. It samples the HEX5..HEX0 segment lines driven by the display encoders and waits for them to stay stable. It then decodes each active-low glyph back to a 4-bit hex value and presents the snapshot to a consumer through a valid/ack handshake. It sits beside the display path so lab self-checks can confirm that the value shown, e.g. `sum` on HEX0, matches the value intended.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive unchanged cycles required before capture; legal range ≥ 1.

Ports:
- `clk`  input  1  single clock; every register is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `HEX5`..`HEX0`  input  8 each  segment buses, active-low; bit order {dp,g,f,e,d,c,b,a}.
- `digits`  output  24  decoded values; HEX5 in [23:20] … HEX0 in [3:0].
- `sum_out`  output  4  copy of `digits[3:0]`.
- `digit_ok`  output  6  per digit: 1 = recognised hex glyph.
- `blank`  output  6  per digit: 1 = segment bits [6:0] all 1.
- `dp`  output  6  per digit: 1 = decimal point lit (bit 7 low).
- `decode_err`  output  1  any captured digit is neither a glyph nor blank.
- `out_valid`  output  1  snapshot pending.
- `out_ack`  input  1  consumer accepts snapshot.
- `overrun`  output  1  sticky; a snapshot was overwritten before ack.

## Operation
- Glyph table on bits [6:0] (bit 7 ignored), hex bytes including dp=1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Blank (x7F on [6:0]) gives value 0, `blank`=1, `digit_ok`=0.
- Any other pattern gives value 0, `digit_ok`=0, `blank`=0.
- Input stage: all 48 bits are registered into `s` every edge.
- Stability counter `cnt`, width clog2(STABLE_CYCLES+1):
  - cleared to 0 whenever the new `s` differs from the old `s`;
  - otherwise increments, saturating at STABLE_CYCLES.
- State machine:
  - SETTLING: on `cnt` reaching STABLE_CYCLES-1 with `s` unchanged, go to STABLE. Capture if `s` ≠ last captured snapshot, or if this is the first capture since reset.
  - STABLE: any change of `s` returns to SETTLING. Equal re-settle produces no new capture.
- Capture action:
  - decode `s` into `digits`, `digit_ok`, `blank`, `dp`, `decode_err`;
  - store raw `s` as the last snapshot;
  - set `out_valid`.
- Handshake:
  - `out_valid` stays high until `out_ack` is sampled high on an edge.
  - Capture while `out_valid`=1 and `out_ack`=0: data overwritten, `out_valid` stays 1, `overrun` set.
  - Capture and `out_ack` on the same edge: new data loaded, `out_valid` stays 1, no overrun.
  - `out_ack` while `out_valid`=0 is ignored.
- `overrun` clears only on reset.

## Timing
- Reset: `digits`, `sum_out`, `digit_ok`, `blank`, `dp`, `decode_err`, `out_valid` and `overrun` are 0. `s`, `cnt` and the snapshot are 0. State is SETTLING. The first-capture flag is armed.
- Reset mid-settle or mid-pending discards everything. The next stable pattern is always captured, even one equal to the pre-reset pattern.
- Latency: if the inputs change and are first sampled into `s` at edge N, and then hold, capture occurs at edge N+STABLE_CYCLES. `out_valid` and the data are high/valid in the cycle after that edge.
- A change at any edge before capture restarts the count from the new value.
- `out_valid` falls on the edge where `out_ack`=1, unless a capture occurs on that same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- STABLE_CYCLES=4, all HEX=FF held from reset release → one capture:
  - `blank`=3F, `digit_ok`=00, `decode_err`=0, `digits`=000000.
  - No further `out_valid` after ack.
- HEX5..HEX0 = F9,A4,B0,99,92,82 held 10 cycles:
  - `out_valid` rises exactly 4 edges after first sample.
  - `digits`=123456, `sum_out`=6, `digit_ok`=3F.
- HEX0 toggles 90↔80 every 2 cycles for 20 cycles, then holds 80:
  - no capture during toggling;
  - a single capture with `sum_out`=8 after settle.
- Two distinct stable patterns captured without ack:
  - `overrun`=1 and remains 1;
  - `digits` show the second pattern.
  - Repeat with ack on the capture edge → `overrun` stays 0.
- HEX2=FE (segment a only) with dp lit on HEX3 (byte 30):
  - `decode_err`=1, `digit_ok[2]`=0, `dp[3]`=1, digit 3 value=3.
- Assert `rst` while `out_valid`=1 → all outputs 0 immediately. Re-present the same pattern → captured again.
